// File: rtl/acc_dump_vout_buffer_ctrl.sv
// Read-back side of the accumulator dump path: fetches dumped lines from DDR through the read
// arbiter, buffers the beats in a FWFT FIFO and streams them out with valid/ready.
module acc_dump_vout_buffer_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 256,
  parameter int unsigned BURST_LEN     = 128,
  parameter int unsigned FIFO_DEPTH    = 256
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     dump_start_i,
  input  logic                     dump_abort_i,
  input  logic [15:0]              dump_line_num_i,
  output logic                     dump_busy_o,
  output logic                     dump_done_o,
  output logic                     dump_ovf_o,
  output logic                     rd_ddr_req_o,
  output logic [7:0]               rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
  input  logic                     rd_ddr_data_vld_i,
  input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
  input  logic                     rd_ddr_finish_i,
  output logic                     dump_vld_o,
  output logic [MEM_DATA_BITS-1:0] dump_data_o,
  input  logic                     dump_rdy_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] SpaceThr = CntW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StWait, StReq, StBurst, StEnd, StDrain, StDone, StFlush
  } state_e;

  state_e                   state_q;
  logic [15:0]              line_num_q;
  logic [15:0]              line_q;
  logic [4:0]               flush_cnt_q;
  logic                     abort_pend_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovf_q;
  logic                     req_q;
  logic [7:0]               len_q;
  logic [ADDR_WIDTH-1:0]    addr_q;

  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q;
  logic [PtrW-1:0]          rd_ptr_q;
  logic [CntW-1:0]          cnt_q;
  logic                     full;
  logic                     burst_phase;
  logic                     wr_en;
  logic                     rd_en;

  // Beats are only accepted while a burst is outstanding on the arbiter.
  assign burst_phase = (state_q == StReq) || (state_q == StBurst);
  assign full        = (cnt_q == FullCnt);
  assign wr_en       = rd_ddr_data_vld_i && burst_phase && !full;
  assign dump_vld_o  = (cnt_q != '0) && (state_q != StFlush);
  assign rd_en       = dump_vld_o && dump_rdy_i;
  assign dump_data_o = dump_vld_o ? mem[rd_ptr_q] : '0;

  assign dump_busy_o   = busy_q;
  assign dump_done_o   = done_q;
  assign dump_ovf_o    = ovf_q;
  assign rd_ddr_req_o  = req_q;
  assign rd_ddr_len_o  = len_q;
  assign rd_ddr_addr_o = addr_q;

  always_ff @(posedge ddr_clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rd_ddr_data_i;
    end
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (state_q == StFlush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !rd_en) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!wr_en && rd_en) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state_q      <= StIdle;
      line_num_q   <= '0;
      line_q       <= '0;
      flush_cnt_q  <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      req_q        <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // An abort during a burst waits until the arbiter reports the burst finished.
      if (dump_abort_i && burst_phase) abort_pend_q <= 1'b1;
      if (rd_ddr_data_vld_i && burst_phase && full) ovf_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (dump_start_i) begin
            busy_q       <= 1'b1;
            line_num_q   <= dump_line_num_i;
            line_q       <= '0;
            ovf_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= (dump_line_num_i == '0) ? StDone : StWait;
          end
        end
        StWait: begin
          if (dump_abort_i || abort_pend_q) begin
            flush_cnt_q <= '0;
            state_q     <= StFlush;
          end else if (cnt_q <= SpaceThr) begin
            req_q   <= 1'b1;
            len_q   <= 8'(BURST_LEN);
            addr_q  <= ADDR_WIDTH'({1'b0, 2'b01, 4'd0, line_q, 7'd0});
            state_q <= StReq;
          end
        end
        StReq: begin
          if (rd_ddr_finish_i) begin
            req_q   <= 1'b0;
            line_q  <= line_q + 1'b1;
            state_q <= StEnd;
          end else if (rd_ddr_data_vld_i) begin
            req_q   <= 1'b0;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (rd_ddr_finish_i) begin
            line_q  <= line_q + 1'b1;
            state_q <= StEnd;
          end
        end
        StEnd: begin
          if (dump_abort_i || abort_pend_q) begin
            flush_cnt_q <= '0;
            state_q     <= StFlush;
          end else if (line_q == line_num_q) begin
            state_q <= StDrain;
          end else begin
            state_q <= StWait;
          end
        end
        StDrain: begin
          if (dump_abort_i) begin
            flush_cnt_q <= '0;
            state_q     <= StFlush;
          end else if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == 5'd31) begin
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_dump_vout_buffer_ctrl.sv
// Directed bench for acc_dump_vout_buffer_ctrl: scenario table plus hand-written corner cases,
// with a behavioural DDR read port and an in-order consumer checker.
module tb_acc_dump_vout_buffer_ctrl;

  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst_n;
  logic          dump_start_i;
  logic          dump_abort_i;
  logic [15:0]   dump_line_num_i;
  logic          dump_busy_o;
  logic          dump_done_o;
  logic          dump_ovf_o;
  logic          rd_ddr_req_o;
  logic [7:0]    rd_ddr_len_o;
  logic [29:0]   rd_ddr_addr_o;
  logic          rd_ddr_data_vld_i;
  logic [DW-1:0] rd_ddr_data_i;
  logic          rd_ddr_finish_i;
  logic          dump_vld_o;
  logic [DW-1:0] dump_data_o;
  logic          dump_rdy_i;

  acc_dump_vout_buffer_ctrl dut (
    .ddr_clk_i         (clk),
    .ddr_rst_n_i       (rst_n),
    .dump_start_i      (dump_start_i),
    .dump_abort_i      (dump_abort_i),
    .dump_line_num_i   (dump_line_num_i),
    .dump_busy_o       (dump_busy_o),
    .dump_done_o       (dump_done_o),
    .dump_ovf_o        (dump_ovf_o),
    .rd_ddr_req_o      (rd_ddr_req_o),
    .rd_ddr_len_o      (rd_ddr_len_o),
    .rd_ddr_addr_o     (rd_ddr_addr_o),
    .rd_ddr_data_vld_i (rd_ddr_data_vld_i),
    .rd_ddr_data_i     (rd_ddr_data_i),
    .rd_ddr_finish_i   (rd_ddr_finish_i),
    .dump_vld_o        (dump_vld_o),
    .dump_data_o       (dump_data_o),
    .dump_rdy_i        (dump_rdy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int line_num;
    int hold;
    int abort_line;
    int inject_line;
    int restart;
    int exp_hold_reqs;
    int exp_hold_ovf;
    int exp_reqs;
    int exp_beats;
    int exp_done;
    int exp_ovf;
  } row_t;

  row_t tbl [5];

  int checks = 0;
  int failures = 0;

  // Counters owned by the DDR model and the consumer monitor; main only reads and snapshots.
  int reqs = 0;
  int addr_bad = 0;
  int beats = 0;
  int order_bad = 0;
  int dones = 0;
  int done_beats = 0;
  int reqs_base = 0;
  int beats_base = 0;
  int cur_abort = -1;
  int cur_inject = -1;

  function automatic logic [DW-1:0] beat_word(int line, int beat);
    logic [15:0] l;
    logic [15:0] b;
    l = line[15:0];
    b = beat[15:0];
    return {8{l, b}};
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // DDR read port: 10-cycle latency, BURST_LEN beats (one extra on the inject line), finish.
  initial begin
    int idx;
    int nb;
    logic [29:0] ea;
    rd_ddr_data_vld_i = 1'b0;
    rd_ddr_data_i     = '0;
    rd_ddr_finish_i   = 1'b0;
    dump_abort_i      = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_ddr_req_o && rst_n) begin
        idx = reqs - reqs_base;
        ea  = {1'b0, 2'b01, 4'd0, idx[15:0], 7'd0};
        if (rd_ddr_addr_o !== ea || rd_ddr_len_o !== 8'd128) addr_bad++;
        reqs++;
        nb = (idx == cur_inject) ? 129 : 128;
        repeat (10) @(posedge clk);
        for (int b = 0; b < nb; b++) begin
          @(posedge clk);
          #1;
          if (!rst_n) break;
          rd_ddr_data_vld_i = 1'b1;
          rd_ddr_data_i     = beat_word(idx, b);
          dump_abort_i      = (idx == cur_abort) && (b == 64);
        end
        if (rst_n) begin
          @(posedge clk);
          #1;
          rd_ddr_data_vld_i = 1'b0;
          dump_abort_i      = 1'b0;
          rd_ddr_finish_i   = 1'b1;
          @(posedge clk);
          #1;
          rd_ddr_finish_i   = 1'b0;
        end else begin
          rd_ddr_data_vld_i = 1'b0;
          dump_abort_i      = 1'b0;
        end
      end
    end
  end

  // Consumer side: every transferred beat must be the next one in line/beat order.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (dump_vld_o && dump_rdy_i) begin
        k = beats - beats_base;
        if (dump_data_o !== beat_word(k / 128, k % 128)) order_bad++;
        beats++;
      end
      if (dump_done_o) begin
        dones++;
        done_beats = beats;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(int budget, string name);
    int n;
    n = 0;
    while (dump_busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, longint'(dump_busy_o), 0);
  endtask

  task automatic pulse_start(logic [15:0] num);
    @(posedge clk);
    #1;
    dump_start_i    = 1'b1;
    dump_line_num_i = num;
    @(posedge clk);
    #1;
    dump_start_i    = 1'b0;
  endtask

  task automatic run_scenario(row_t r, string name);
    int d0;
    int ab0;
    int ob0;
    reqs_base  = reqs;
    beats_base = beats;
    d0         = dones;
    ab0        = addr_bad;
    ob0        = order_bad;
    cur_abort  = r.abort_line;
    cur_inject = r.inject_line;
    dump_rdy_i = (r.hold == 0);
    pulse_start(16'(r.line_num));
    @(negedge clk);
    check({name, "_busy_on_start"}, longint'(dump_busy_o), 1);
    check({name, "_ovf_clr_on_start"}, longint'(dump_ovf_o), 0);
    if (r.restart != 0) begin
      repeat (50) @(posedge clk);
      pulse_start(16'd7);
    end
    if (r.hold > 0) begin
      repeat (r.hold) @(posedge clk);
      @(negedge clk);
      check({name, "_hold_reqs"}, longint'(reqs - reqs_base), r.exp_hold_reqs);
      check({name, "_hold_ovf"}, longint'(dump_ovf_o), r.exp_hold_ovf);
      @(posedge clk);
      #1;
      dump_rdy_i = 1'b1;
    end
    wait_idle(20000, name);
    repeat (3) @(negedge clk);
    check({name, "_reqs"}, longint'(reqs - reqs_base), r.exp_reqs);
    if (r.exp_beats >= 0) check({name, "_beats"}, longint'(beats - beats_base), r.exp_beats);
    check({name, "_done_count"}, longint'(dones - d0), r.exp_done);
    if (r.exp_done > 0) begin
      check({name, "_done_after_last"}, longint'(done_beats - beats_base), r.exp_beats);
    end
    check({name, "_ovf_end"}, longint'(dump_ovf_o), r.exp_ovf);
    check({name, "_vld_end"}, longint'(dump_vld_o), 0);
    check({name, "_addr_len"}, longint'(addr_bad - ab0), 0);
    check({name, "_order"}, longint'(order_bad - ob0), 0);
  endtask

  initial begin
    int n;
    int r0;
    //            num  hold  abort inj rst hreq hovf reqs beats done ovf
    tbl[0] = '{3,    0,    -1,  -1, 0,  0,   0,   3,   384,  1,   0};
    tbl[1] = '{4,    2000, -1,  -1, 0,  2,   0,   4,   512,  1,   0};
    tbl[2] = '{2,    600,  -1,  1,  0,  2,   1,   2,   256,  1,   1};
    tbl[3] = '{4,    0,    1,   -1, 0,  0,   0,   2,   -1,   0,   0};
    tbl[4] = '{2,    0,    -1,  -1, 1,  0,   0,   2,   256,  1,   0};

    rst_n           = 1'b1;
    dump_start_i    = 1'b0;
    dump_line_num_i = '0;
    dump_rdy_i      = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(dump_busy_o), 0);
    check("rst_done", longint'(dump_done_o), 0);
    check("rst_ovf", longint'(dump_ovf_o), 0);
    check("rst_req", longint'(rd_ddr_req_o), 0);
    check("rst_len", longint'(rd_ddr_len_o), 0);
    check("rst_addr", longint'(rd_ddr_addr_o), 0);
    check("rst_vld", longint'(dump_vld_o), 0);
    check("rst_data_zero", longint'(dump_data_o != '0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_scenario(tbl[i], $sformatf("row%0d", i));
    end

    // line_num = 0 goes straight to DONE without touching DDR.
    r0 = reqs;
    n  = dones;
    pulse_start(16'd0);
    @(negedge clk);
    check("zero_done_c1", longint'(dump_done_o), 0);
    check("zero_busy_c1", longint'(dump_busy_o), 1);
    @(negedge clk);
    check("zero_done_c2", longint'(dump_done_o), 1);
    @(negedge clk);
    check("zero_done_c3", longint'(dump_done_o), 0);
    check("zero_busy_c3", longint'(dump_busy_o), 0);
    check("zero_no_req", longint'(reqs - r0), 0);
    check("zero_done_count", longint'(dones - n), 1);

    // Asynchronous reset in the middle of a burst.
    reqs_base  = reqs;
    beats_base = beats;
    cur_abort  = -1;
    cur_inject = -1;
    dump_rdy_i = 1'b1;
    pulse_start(16'd3);
    n = 0;
    while (!rd_ddr_data_vld_i && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_burst_seen", longint'(rd_ddr_data_vld_i), 1);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", longint'(dump_busy_o), 0);
    check("rstmid_req", longint'(rd_ddr_req_o), 0);
    check("rstmid_addr", longint'(rd_ddr_addr_o), 0);
    check("rstmid_len", longint'(rd_ddr_len_o), 0);
    check("rstmid_vld", longint'(dump_vld_o), 0);
    check("rstmid_data_zero", longint'(dump_data_o != '0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_scenario(tbl[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
